mole_round_ctrl: RTL and testbench

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

---
 rtl/mole_round_ctrl.sv | 157 +++++++++++++++
 tb/tb_mole_round_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_ctrl.sv
// ---------------------------------------------------------------------------
// mole_round_ctrl
// Round sequencer for a whack-a-mole game. A start request launches a game
// of NUM_ROUNDS rounds. Each round restarts the external interval timer,
// raises the mole, and ends on either a player hit (scored) or a timer
// timeout (not scored). The timer interval shrinks by one second every two
// completed rounds, down to INTERVAL_MIN.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   start        : one-cycle game-start request (ignored while busy)
//   hit          : one-cycle debounced player-hit pulse
//   timeout      : one-cycle terminal-count pulse from the interval timer
//   timer_reset  : one-cycle timer restart, high in ARM
//   interval     : seconds for the timer to count
//   dir          : timer count direction, always 0 (count down)
//   mole_active  : high while a mole is up (ACTIVE)
//   round        : number of completed rounds
//   score        : number of rounds won by a hit
//   busy         : high in ARM, ACTIVE, ADVANCE
//   done         : high in DONE, holds until start or rst
// ---------------------------------------------------------------------------
module mole_round_ctrl #(
    parameter int NUM_ROUNDS     = 8,
    parameter int INTERVAL_START = 5,
    parameter int INTERVAL_MIN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       timeout,
    output logic       timer_reset,
    output logic [2:0] interval,
    output logic       dir,
    output logic       mole_active,
    output logic [3:0] round,
    output logic [3:0] score,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LP_NUM   = 4'(NUM_ROUNDS);
    localparam logic [2:0] LP_START = 3'(INTERVAL_START);
    localparam logic [2:0] LP_MIN   = 3'(INTERVAL_MIN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_ACTIVE  = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_round;
    logic [3:0] r_score;
    logic [2:0] r_interval;
    logic       r_timer_reset;
    logic       r_mole_active;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_round_next;
    logic [2:0] w_half;
    logic [2:0] w_interval_next;
    logic       w_last_round;

    // Round count after the current round closes, and the interval it implies
    always_comb begin
        w_round_next    = r_round + 4'd1;
        w_half          = w_round_next[3:1];
        w_last_round    = (w_round_next == LP_NUM);
        w_interval_next = LP_START;
        // Clamp at the floor instead of letting the subtraction underflow
        if (({1'b0, w_half} + {1'b0, LP_MIN}) >= {1'b0, LP_START}) begin
            w_interval_next = LP_MIN;
        end else begin
            w_interval_next = LP_START - w_half;
        end
    end

    // Game FSM with registered outputs; reset dominates every input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_round       <= 4'd0;
            r_score       <= 4'd0;
            r_interval    <= LP_START;
            r_timer_reset <= 1'b0;
            r_mole_active <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                // DONE restarts exactly like IDLE; final results held until then
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_ARM;
                        r_round       <= 4'd0;
                        r_score       <= 4'd0;
                        r_interval    <= LP_START;
                        r_timer_reset <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                S_ARM: begin
                    r_state       <= S_ACTIVE;
                    r_timer_reset <= 1'b0;
                    r_mole_active <= 1'b1;
                end
                // Hit is tested first so a coincident timeout cannot steal the point
                S_ACTIVE: begin
                    if (hit) begin
                        r_state       <= S_ADVANCE;
                        r_score       <= r_score + 4'd1;
                        r_mole_active <= 1'b0;
                    end else if (timeout) begin
                        r_state       <= S_ADVANCE;
                        r_mole_active <= 1'b0;
                    end
                end
                S_ADVANCE: begin
                    r_round    <= w_round_next;
                    r_interval <= w_interval_next;
                    if (w_last_round) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state       <= S_ARM;
                        r_timer_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_timer_reset <= 1'b0;
                    r_mole_active <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign timer_reset = r_timer_reset;
    assign interval    = r_interval;
    assign dir         = 1'b0;
    assign mole_active = r_mole_active;
    assign round       = r_round;
    assign score       = r_score;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mole_round_ctrl
// Three instances share one stimulus stream: u_dut_a (NUM_ROUNDS=4),
// u_dut_b (defaults) and u_dut_c (INTERVAL_START=3). Expected round/score/
// interval of u_dut_a are queued when a hit/timeout/start is driven and
// popped at every ARM cycle and at the rise of done.
// ---------------------------------------------------------------------------
module tb_mole_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic hit = 1'b0;
    logic timeout = 1'b0;

    logic       a_timer_reset, a_dir, a_mole_active, a_busy, a_done;
    logic [2:0] a_interval;
    logic [3:0] a_round, a_score;
    logic       b_timer_reset, b_dir, b_mole_active, b_busy, b_done;
    logic [2:0] b_interval;
    logic [3:0] b_round, b_score;
    logic       c_timer_reset, c_dir, c_mole_active, c_busy, c_done;
    logic [2:0] c_interval;
    logic [3:0] c_round, c_score;

    mole_round_ctrl #(.NUM_ROUNDS(4), .INTERVAL_START(5), .INTERVAL_MIN(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .timeout(timeout),
        .timer_reset(a_timer_reset), .interval(a_interval), .dir(a_dir),
        .mole_active(a_mole_active), .round(a_round), .score(a_score),
        .busy(a_busy), .done(a_done));

    mole_round_ctrl u_dut_b (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .timeout(timeout),
        .timer_reset(b_timer_reset), .interval(b_interval), .dir(b_dir),
        .mole_active(b_mole_active), .round(b_round), .score(b_score),
        .busy(b_busy), .done(b_done));

    mole_round_ctrl #(.NUM_ROUNDS(8), .INTERVAL_START(3), .INTERVAL_MIN(1)) u_dut_c (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .timeout(timeout),
        .timer_reset(c_timer_reset), .interval(c_interval), .dir(c_dir),
        .mole_active(c_mole_active), .round(c_round), .score(c_score),
        .busy(c_busy), .done(c_done));

    always #5 clk = ~clk;

    typedef struct {
        int rnd;
        int scr;
        int ivl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   tr_cnt   = 0;
    bit   rec_en   = 1'b0;
    int   b_ivl[8];
    int   c_ivl[8];
    int   b_idx = 0;
    int   c_idx = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_ivl(input int st, input int mn, input int rnd);
        int v;
        v = st - (rnd >> 1);
        return (v < mn) ? mn : v;
    endfunction

    function automatic void push_exp(input int rnd, input int scr, input int ivl);
        exp_t e;
        e.rnd = rnd;
        e.scr = scr;
        e.ivl = ivl;
        sb_q.push_back(e);
    endfunction

    // Monitor: scoreboard pops for u_dut_a, timer_reset width, interval capture
    initial begin
        logic a_done_d = 1'b0;
        logic a_tr_d   = 1'b0;
        logic b_ma_d   = 1'b0;
        logic c_ma_d   = 1'b0;
        int   tr_len   = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_timer_reset === 1'b1 || (a_done === 1'b1 && a_done_d === 1'b0)) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("sb_round", int'(a_round), e.rnd);
                    check_val("sb_score", int'(a_score), e.scr);
                    check_val("sb_interval", int'(a_interval), e.ivl);
                end
            end
            if (a_timer_reset === 1'b1) tr_len++;
            if (a_tr_d === 1'b1 && a_timer_reset === 1'b0) begin
                check_val("tr_width", tr_len, 1);
                tr_cnt++;
                tr_len = 0;
            end
            if (rec_en && b_mole_active === 1'b1 && b_ma_d === 1'b0 && b_idx < 8) begin
                b_ivl[b_idx] = int'(b_interval);
                b_idx++;
            end
            if (rec_en && c_mole_active === 1'b1 && c_ma_d === 1'b0 && c_idx < 8) begin
                c_ivl[c_idx] = int'(c_interval);
                c_idx++;
            end
            a_done_d = a_done;
            a_tr_d   = a_timer_reset;
            b_ma_d   = b_mole_active;
            c_ma_d   = c_mole_active;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_in(input bit do_hit, input bit do_to);
        hit     = do_hit;
        timeout = do_to;
        @(negedge clk);
        hit     = 1'b0;
        timeout = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the mole (of u_dut_b or u_dut_a); returns negedges waited
    task automatic wait_mole(input bit use_b, output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if ((use_b ? b_mole_active : a_mole_active) === 1'b1) return;
        end
        check_val("mole_wait_expired", 0, 1);
    endtask

    task automatic wait_done_a();
        for (int k = 0; k < 40; k++) begin
            if (a_done === 1'b1) return;
            @(negedge clk);
        end
        check_val("done_wait_expired", 0, 1);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_round"}, int'(a_round), 0);
        check_val({tag, "_score"}, int'(a_score), 0);
        check_val({tag, "_interval"}, int'(a_interval), 5);
        check_val({tag, "_tr"}, int'(a_timer_reset), 0);
        check_val({tag, "_mole"}, int'(a_mole_active), 0);
        check_val({tag, "_busy"}, int'(a_busy), 0);
        check_val({tag, "_done"}, int'(a_done), 0);
        check_val({tag, "_dir"}, int'(a_dir), 0);
    endtask

    initial begin
        int n;
        int tbl_b[8] = '{5, 5, 4, 4, 3, 3, 2, 2};
        int tbl_c[8] = '{3, 3, 2, 2, 1, 1, 1, 1};

        // Reset, then idle with random hit/timeout noise
        @(negedge clk);
        do_reset();
        check_idle("rst");
        check_val("rst_c_interval", int'(c_interval), 3);
        for (int i = 0; i < 10; i++) begin
            hit     = 1'($urandom_range(0, 1));
            timeout = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        hit     = 1'b0;
        timeout = 1'b0;
        @(negedge clk);
        check_idle("idle_noise");

        // All-hit game on the 4-round instance
        tr_cnt = 0;
        push_exp(0, 0, 5);
        pulse_start();
        for (int r = 0; r < 4; r++) begin
            wait_mole(1'b0, n);
            check_val(r == 0 ? "start_to_mole" : "hit_to_mole", n, r == 0 ? 1 : 2);
            repeat (5) @(negedge clk);
            push_exp(r + 1, r + 1, exp_ivl(5, 1, r + 1));
            pulse_in(1'b1, 1'b0);
            check_val("score_next_cycle", int'(a_score), r + 1);
        end
        wait_done_a();
        @(negedge clk);
        check_val("hits_done", int'(a_done), 1);
        check_val("hits_busy", int'(a_busy), 0);
        check_val("hits_score", int'(a_score), 4);
        check_val("hits_round", int'(a_round), 4);
        check_val("hits_tr_pulses", tr_cnt, 4);
        pulse_in(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_val("done_hold", int'(a_done), 1);
        check_val("done_hold_score", int'(a_score), 4);

        // Timeout-only game; pre-start timeout must be ignored
        do_reset();
        pulse_in(1'b0, 1'b1);
        @(negedge clk);
        check_val("prestart_score", int'(a_score), 0);
        check_val("prestart_busy", int'(a_busy), 0);
        push_exp(0, 0, 5);
        pulse_start();
        for (int r = 0; r < 4; r++) begin
            wait_mole(1'b0, n);
            repeat (2) @(negedge clk);
            push_exp(r + 1, 0, exp_ivl(5, 1, r + 1));
            pulse_in(1'b0, 1'b1);
        end
        wait_done_a();
        @(negedge clk);
        check_val("to_done", int'(a_done), 1);
        check_val("to_score", int'(a_score), 0);
        check_val("to_round", int'(a_round), 4);

        // Restart from DONE, start while busy, coincident hit+timeout
        push_exp(0, 0, 5);
        pulse_start();
        check_val("restart_done_low", int'(a_done), 0);
        wait_mole(1'b0, n);
        pulse_start();
        check_val("busy_start_mole", int'(a_mole_active), 1);
        check_val("busy_start_round", int'(a_round), 0);
        push_exp(1, 1, 5);
        pulse_in(1'b1, 1'b1);
        wait_mole(1'b0, n);
        repeat (3) @(negedge clk);
        check_val("coincide_round", int'(a_round), 1);
        check_val("coincide_score", int'(a_score), 1);
        push_exp(2, 2, 4);
        pulse_in(1'b1, 1'b0);
        wait_mole(1'b0, n);
        check_val("pre_rst_score", int'(a_score), 2);

        // Reset in ACTIVE, then a fresh game
        rst = 1'b1;
        start = 1'b1;
        hit = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        hit = 1'b0;
        check_idle("rst_active");
        push_exp(0, 0, 5);
        pulse_start();
        wait_mole(1'b0, n);
        check_val("fresh_round", int'(a_round), 0);
        check_val("fresh_score", int'(a_score), 0);

        // Interval schedule on the two 8-round instances
        rst = 1'b1;
        rec_en = 1'b1;
        b_idx = 0;
        c_idx = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_exp(0, 0, 5);
        pulse_start();
        for (int r = 0; r < 8; r++) begin
            wait_mole(1'b1, n);
            @(negedge clk);
            if (r < 4) push_exp(r + 1, r + 1, exp_ivl(5, 1, r + 1));
            pulse_in(1'b1, 1'b0);
        end
        repeat (3) @(negedge clk);
        check_val("b_count", b_idx, 8);
        check_val("c_count", c_idx, 8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("b_ivl%0d", i), b_ivl[i], tbl_b[i]);
            check_val($sformatf("c_ivl%0d", i), c_ivl[i], tbl_c[i]);
        end
        check_val("b_done", int'(b_done), 1);
        check_val("b_round", int'(b_round), 8);
        check_val("b_score", int'(b_score), 8);
        check_val("b_dir", int'(b_dir), 0);
        check_val("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
